// File: rtl/prefix_adder_pkg.sv
// ---------------------------------------------------------------------------
// prefix_adder_pkg
//   Shared types and elaboration-time helpers for the pipelined prefix adder.
//
//   pg_t        : one prefix column's (propagate, generate) pair.
//   black_cell  : group combine of a high-order span with the adjacent
//                 low-order span.
//   lf_partner  : for a column i (-1..WIDTH-1) and prefix level, returns the
//                 column whose group is combined into column i at that level,
//                 or PASS_THROUGH when column i is unchanged.
// ---------------------------------------------------------------------------
package prefix_adder_pkg;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    localparam int PASS_THROUGH = -2;

    function automatic pg_t black_cell(pg_t hi, pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    // Columns are numbered -1..WIDTH-1, so j = i+1 is the 0-based position.
    // A column whose position has bit `level` set sits in the upper half of a
    // 2^(level+1) block; it absorbs the group ending at the last column of the
    // lower half, i.e. position (j with the low `level` bits cleared) - 1,
    // which is column (that position) - 1.
    function automatic int lf_partner(int i, int level);
        int j;
        j = i + 1;
        if (i < 0) begin
            return PASS_THROUGH;
        end
        if (((j >> level) & 1) == 0) begin
            return PASS_THROUGH;
        end
        return ((j >> level) << level) - 2;
    endfunction

endpackage

// File: rtl/prefix_level_stage.sv
// ---------------------------------------------------------------------------
// prefix_level_stage
//   One registered level of the Ladner-Fischer prefix tree. Column c of the
//   vectors holds prefix column c-1 (bit 0 is the carry-in column).
//
//   Parameters
//     WIDTH     operand width
//     LEVEL     prefix level applied by this stage (0-based)
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     advance               global pipeline enable
//     valid_in / valid_out  beat valid entering / leaving this stage
//     p_in,  g_in,  x_in    per-column propagate, generate, half-sum in
//     p_out, g_out, x_out   registered results of this level
// ---------------------------------------------------------------------------
module prefix_level_stage
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             valid_in,
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH:0]   g_in,
    input  logic [WIDTH:0]   x_in,
    output logic             valid_out,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH:0]   g_out,
    output logic [WIDTH:0]   x_out
);

    logic [WIDTH:0] w_p;
    logic [WIDTH:0] w_g;

    logic           r_valid;
    logic [WIDTH:0] r_p;
    logic [WIDTH:0] r_g;
    logic [WIDTH:0] r_x;

    for (genvar c = 0; c <= WIDTH; c++) begin : g_col
        localparam int PARTNER = lf_partner(c - 1, LEVEL);
        if (PARTNER == PASS_THROUGH) begin : g_pass
            assign w_p[c] = p_in[c];
            assign w_g[c] = g_in[c];
        end else begin : g_black
            pg_t w_res;
            assign w_res  = black_cell(pg_t'({p_in[c], g_in[c]}),
                                       pg_t'({p_in[PARTNER + 1], g_in[PARTNER + 1]}));
            assign w_p[c] = w_res.p;
            assign w_g[c] = w_res.g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_p     <= '0;
            r_g     <= '0;
            r_x     <= '0;
        end else if (advance) begin
            r_valid <= valid_in;
            r_p     <= w_p;
            r_g     <= w_g;
            r_x     <= x_in;
        end
    end

    assign valid_out = r_valid;
    assign p_out     = r_p;
    assign g_out     = r_g;
    assign x_out     = r_x;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// ---------------------------------------------------------------------------
// pipelined_prefix_adder
//   Pipelined Ladner-Fischer adder/subtractor with a valid/ready stream.
//   One input register (p/g/x generation) followed by LEVELS prefix stages;
//   results are decoded combinationally from the last stage.
//
//   Handshake: a beat moves on an edge where valid & ready are both 1. The
//   whole pipe shares one enable, advance = !out_valid | out_ready, and
//   in_ready = advance. When the output beat is not taken, every stage holds,
//   so sum/c_out/ovf stay stable. Empty slots travel as valid=0 bubbles.
//
//   Parameters
//     WIDTH      operand width, power of two, 4..64
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operand beat handshake
//     a, b, c_in, sub       operands; sub=1 computes a-b and ignores c_in
//     out_valid / out_ready result beat handshake
//     sum, c_out, ovf       result, carry out (no-borrow on sub), overflow
// ---------------------------------------------------------------------------
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH) + 1;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    logic             r_v0;
    logic [WIDTH:0]   r_p0;
    logic [WIDTH:0]   r_g0;
    logic [WIDTH:0]   r_x0;

    // Index 0 is the input register, index k the output of prefix stage k.
    logic             w_v [LEVELS+1];
    logic [WIDTH:0]   w_p [LEVELS+1];
    logic [WIDTH:0]   w_g [LEVELS+1];
    logic [WIDTH:0]   w_x [LEVELS+1];

    logic             w_unused;

    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance;

    assign w_b_eff   = b ^ {WIDTH{sub}};
    assign w_cin_eff = sub | c_in;

    // Column -1 (bit 0) carries the effective carry-in as a pure generate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_p0 <= '0;
            r_g0 <= '0;
            r_x0 <= '0;
        end else if (w_advance) begin
            r_v0 <= in_valid;
            r_p0 <= {a | w_b_eff, 1'b0};
            r_g0 <= {a & w_b_eff, w_cin_eff};
            r_x0 <= {a ^ w_b_eff, 1'b0};
        end
    end

    assign w_v[0] = r_v0;
    assign w_p[0] = r_p0;
    assign w_g[0] = r_g0;
    assign w_x[0] = r_x0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
        prefix_level_stage #(
            .WIDTH (WIDTH),
            .LEVEL (k - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (w_advance),
            .valid_in  (w_v[k-1]),
            .p_in      (w_p[k-1]),
            .g_in      (w_g[k-1]),
            .x_in      (w_x[k-1]),
            .valid_out (w_v[k]),
            .p_out     (w_p[k]),
            .g_out     (w_g[k]),
            .x_out     (w_x[k])
        );
    end

    // After the last level, bit c of g holds G[c-1:-1], the carry into
    // column c. Group propagate and the carry-in column's x are not needed.
    assign out_valid = w_v[LEVELS];
    assign sum       = w_x[LEVELS][WIDTH:1] ^ w_g[LEVELS][WIDTH-1:0];
    assign c_out     = w_g[LEVELS][WIDTH];
    assign ovf       = w_g[LEVELS][WIDTH-1] ^ w_g[LEVELS][WIDTH];

    assign w_unused  = ^{w_p[LEVELS], w_x[LEVELS][0]};

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;

    localparam int W   = 16;
    localparam int LAT = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (WIDTH=16) ----------------
    logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [W-1:0] a, b, sum;

    pipelined_prefix_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    // ---------------- regression DUTs (WIDTH=4/32/64) ----------------
    logic        rv, rc, rs, rrdy;
    logic [63:0] ra, rb;
    logic        ir4, ov4, co4, of4;
    logic        ir32, ov32, co32, of32;
    logic        ir64, ov64, co64, of64;
    logic [3:0]  s4;
    logic [31:0] s32;
    logic [63:0] s64;

    pipelined_prefix_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir4),
        .a(ra[3:0]), .b(rb[3:0]), .c_in(rc), .sub(rs), .out_valid(ov4),
        .out_ready(rrdy), .sum(s4), .c_out(co4), .ovf(of4)
    );
    pipelined_prefix_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir32),
        .a(ra[31:0]), .b(rb[31:0]), .c_in(rc), .sub(rs), .out_valid(ov32),
        .out_ready(rrdy), .sum(s32), .c_out(co32), .ovf(of32)
    );
    pipelined_prefix_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir64),
        .a(ra), .b(rb), .c_in(rc), .sub(rs), .out_valid(ov64),
        .out_ready(rrdy), .sum(s64), .c_out(co64), .ovf(of64)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_recv  = 0;
    logic sb_en = 1'b0;
    logic [W+1:0] exp_q[$];   // {c_out, ovf, sum}

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur within its bound", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer add/subtract on w-bit operands.
    function automatic void ref_model(input logic [63:0] ia, input logic [63:0] ib,
                                      input logic cin, input logic isub, input int w,
                                      output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] full;
        logic [63:0] mask, ma, mb;
        logic        sa, sb, sr;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ma = ia & mask;
        mb = ib & mask;
        if (isub) begin
            full = {1'b0, ma} - {1'b0, mb};
            co   = (ma >= mb);
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {64'd0, cin};
            co   = full[w];
        end
        s  = full[63:0] & mask;
        sa = ma[w-1];
        sb = mb[w-1];
        sr = s[w-1];
        ov = isub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] ms;
        logic        mco, mov;
        logic [W+1:0] e;
        if (rst_n && sb_en) begin
            if (in_valid && in_ready) begin
                ref_model({48'd0, a}, {48'd0, b}, c_in, sub, W, ms, mco, mov);
                exp_q.push_back({mco, mov, ms[W-1:0]});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("sb_unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", 64'({c_out, ovf, sum}), 64'(e));
                    n_recv++;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic rand_beat();
        a    = 16'($urandom);
        b    = 16'($urandom);
        c_in = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
    endtask

    task automatic send_single(input string nm, input logic [15:0] ta, input logic [15:0] tbv,
                               input logic tc, input logic ts,
                               input logic [15:0] es, input logic eco, input logic eov);
        int lat;
        a = ta; b = tbv; c_in = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) begin
            fail_now({nm, "_timeout"});
        end else begin
            check({nm, "_latency"}, 64'(lat), 64'(LAT));
            check({nm, "_sum"}, 64'(sum), 64'(es));
            check({nm, "_c_out"}, 64'(c_out), 64'(eco));
            check({nm, "_ovf"}, 64'(ovf), 64'(eov));
        end
        step();
    endtask

    typedef struct {
        string       nm;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    // ---------------- test sequence ----------------
    initial begin
        int sent, cyc, lat;
        logic need_new;
        logic [W+1:0] held;
        logic [63:0] es4, es32, es64;
        logic eco4, eov4, eco32, eov32, eco64, eov64;
        logic seen4, seen32, seen64;

        vecs[0] = '{"ffff_plus_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{"pos_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{"sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_cin_ign",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"cin_only",     16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{"neg_ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{"plain_add",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[7] = '{"all_ones_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{"sub_equal",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        rv = 1'b0; rrdy = 1'b1; ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;

        // reset state
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_c_out", 64'(c_out), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // directed vectors
        foreach (vecs[i]) begin
            send_single(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                        vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // random back-to-back stream with out_ready toggling every 3 cycles
        sb_en = 1'b1;
        n_recv = 0;
        sent = 0; cyc = 0; need_new = 1'b1;
        while (sent < 64 && cyc < 2000) begin
            out_ready = ((cyc / 3) % 2) == 0;
            if (need_new) rand_beat();
            in_valid = 1'b1;
            #1;
            need_new = in_ready;
            if (in_ready) sent++;
            step();
            cyc++;
        end
        if (sent < 64) fail_now("stream_send");
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(n_recv), 64'd64);

        // fill the pipe with the consumer stalled, hold, then drain
        out_ready = 1'b0;
        need_new = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (need_new) rand_beat();
            in_valid = 1'b1;
            need_new = in_ready;
            step();
        end
        held = {c_out, ovf, sum};
        step();
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'({c_out, ovf, sum}), 64'(held));
            step();
        end
        check("stall_queue_depth", 64'(exp_q.size()), 64'(LAT + 1));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            check("drain_rate", 64'(out_valid), 64'd1);
            step();
        end
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        // asynchronous reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(sum), 64'd0);
        check("async_rst_c_out", 64'(c_out), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_release_in_ready", 64'(in_ready), 64'd1);
        check("rst_release_out_valid", 64'(out_valid), 64'd0);
        send_single("after_reset", 16'd3, 16'd4, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0);

        // width regression: latency and result for WIDTH=4, 32, 64
        for (int t = 0; t < 20; t++) begin
            if (t == 0) begin
                ra = '1; rb = 64'd1; rc = 1'b0; rs = 1'b0;
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
            end
            ref_model(ra, rb, rc, rs, 4,  es4,  eco4,  eov4);
            ref_model(ra, rb, rc, rs, 32, es32, eco32, eov32);
            ref_model(ra, rb, rc, rs, 64, es64, eco64, eov64);
            rv = 1'b1;
            step();
            rv = 1'b0;
            seen4 = 1'b0; seen32 = 1'b0; seen64 = 1'b0;
            lat = 0;
            while (!(seen4 && seen32 && seen64) && lat < 20) begin
                step();
                lat++;
                if (ov4 && !seen4) begin
                    seen4 = 1'b1;
                    check("w4_latency", 64'(lat), 64'd3);
                    check("w4_result", 64'({co4, of4, s4}), 64'({eco4, eov4, es4[3:0]}));
                end
                if (ov32 && !seen32) begin
                    seen32 = 1'b1;
                    check("w32_latency", 64'(lat), 64'd6);
                    check("w32_result", 64'({co32, of32, s32}), 64'({eco32, eov32, es32[31:0]}));
                end
                if (ov64 && !seen64) begin
                    seen64 = 1'b1;
                    check("w64_latency", 64'(lat), 64'd7);
                    check("w64_sum", s64, es64);
                    check("w64_flags", 64'({co64, of64}), 64'({eco64, eov64}));
                end
            end
            if (!seen4)  fail_now("w4_timeout");
            if (!seen32) fail_now("w32_timeout");
            if (!seen64) fail_now("w64_timeout");
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
